prio_event_enc: RTL and testbench
=================================

PRIO_EVENT_ENC -- requirements
Module: prio_event_enc

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning the number of event inputs; legal values are powers of two from 2 to 64.
REQ-002 The module SHALL have parameter W, default 3, meaning the index width; W SHALL equal log2(N).
REQ-003 Port ck  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Port res  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port din  input  N  SHALL carry event requests, one bit per source; bit i set for one cycle means one event from source i.
REQ-006 Port en  input  1  SHALL enable capture; din is ignored while en=0.
REQ-007 Port clr  input  1  SHALL be the synchronous clear of all pending state.
REQ-008 Port mode  input  1  SHALL select arbitration: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-009 Port dout  output  W  SHALL carry the index of the offered event.
REQ-010 Port valid  output  1  SHALL indicate that dout is a valid offer.
REQ-011 Port ready  input  1  SHALL indicate consumer acceptance; valid=1 and ready=1 at a rising edge is a handshake.
REQ-012 Port pending  output  N  SHALL mirror the internal pending-event register.
REQ-013 Port overflow  output  1  SHALL be the sticky flag for a lost event.

Function
REQ-014 pend[N-1:0] SHALL be a register. pend_next = clr ? 0 : (pend & ~served) | (en ? din : 0). served is the one-hot bit of dout on a handshake edge, else 0.
REQ-015 A din bit equal to the bit being served in the same cycle SHALL leave that bit set, and SHALL NOT set overflow.
REQ-016 overflow SHALL be set when en=1 and din[i]=1 while pend[i]=1 and bit i is not being served; it SHALL stay set until clr or reset.
REQ-017 The output register SHALL be "free" when valid=0 or a handshake occurs.
REQ-018 On a free edge, valid SHALL load |pend_next and dout SHALL load sel(pend_next); on a non-free edge, dout and valid SHALL hold.
REQ-019 While valid=1 and ready=0, dout SHALL NOT change, even if higher-priority events arrive.
REQ-020 Fixed mode: sel(p) SHALL be the highest set index of p.
REQ-021 Round-robin mode: sel(p) SHALL be the first set index found searching ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
REQ-022 ptr SHALL be a W-bit register. On each handshake, ptr SHALL load (dout-1) mod N in both modes.
REQ-023 Round-robin selection SHALL use ptr_next, so a back-to-back offer already reflects the new rotation.
REQ-024 Latency: a din event driven in cycle k SHALL appear on valid/dout in cycle k+1 if the output register is free.
REQ-025 Throughput: one handshake per cycle SHALL be sustained while events are pending.
REQ-026 sel(0) SHALL yield dout=0 with valid=0.
REQ-027 A mode change SHALL affect only the next free-edge load.
REQ-028 clr SHALL have priority over din, handshake and ptr update.
REQ-029 On clr, pend, overflow and valid SHALL be 0, dout SHALL be 0, and ptr SHALL be N-1.
REQ-030 There SHALL be no combinational path from din, en, mode or ready to any output.

Reset
REQ-031 While res=0, the block SHALL immediately drive pend=0, pending=0, dout=0, valid=0 and overflow=0, and set ptr=N-1.
REQ-032 Reset asserted mid-offer SHALL drop valid without a handshake; the pending event is lost and not reported.
REQ-033 After res is released, the first rising edge SHALL behave as a normal edge from the reset state.

Verification (N=8)
REQ-034 Fixed mode, ready=1, din=8'b0010_0100 for one cycle -> next cycle dout=5 valid=1; following cycle dout=2 valid=1; then valid=0, pending=0.
REQ-035 Fixed mode, ready=0, din=8'h01 -> dout=0 valid=1. Then din=8'h80 -> dout stays 0 and pending=8'h81. Then ready=1 -> dout=0 then dout=7.
REQ-036 Round-robin, ready=1, din=8'hFF once -> dout sequence 7,6,5,4,3,2,1,0. Then din=8'h81 -> dout=7 then 0. Then din=8'h81 again -> dout=7 first, since ptr=7 after serving index 0.
REQ-037 din[3] pulsed twice while pend[3]=1 and ready=0 -> overflow=1, pending=8'h08. Then clr=1 -> pending=0, overflow=0, valid=0 next cycle.
REQ-038 Handshake on dout=4 with din[4]=1 in the same cycle -> pend[4] stays 1, overflow stays 0, and 4 is offered again.
REQ-039 res pulsed low asynchronously mid-cycle while valid=1 -> all outputs 0 immediately. With en=0 and din=8'hFF, pending stays 0.

Source files
------------

// File: rtl/prio_event_enc.sv
// Pending-event collector with a registered, handshake-held offer of one event index.
// Arbitration is fixed priority (highest index) or round-robin from a rotating pointer.
module prio_event_enc #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         ck,
    input  logic         res,
    input  logic [N-1:0] din,
    input  logic         en,
    input  logic         clr,
    input  logic         mode,
    output logic [W-1:0] dout,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] dout_q, dout_d;
    logic         valid_q, valid_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         ovf_q, ovf_d;

    logic         hs;
    logic         free;
    logic [N-1:0] served;
    logic [N-1:0] din_eff;

    // Round-robin searches downward from ptr with wrap; fixed picks the highest set bit.
    function automatic logic [W-1:0] sel_idx(input logic [N-1:0] p,
                                             input logic [W-1:0] ptr,
                                             input logic         rr);
        logic [W-1:0] idx;
        logic [W-1:0] cand;
        logic         found;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        if (rr) begin
            for (int k = 0; k < N; k++) begin
                cand = ptr - W'(k);
                if (!found && p[cand]) begin
                    idx   = cand;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (p[i]) idx = W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        hs      = valid_q & ready;
        free    = ~valid_q | hs;
        din_eff = en ? din : '0;
        served  = '0;
        if (hs) served[dout_q] = 1'b1;

        pend_d  = pend_q;
        ovf_d   = ovf_q;
        ptr_d   = ptr_q;
        dout_d  = dout_q;
        valid_d = valid_q;

        if (clr) begin
            pend_d  = '0;
            ovf_d   = 1'b0;
            ptr_d   = W'(N - 1);
            dout_d  = '0;
            valid_d = 1'b0;
        end else begin
            // A re-request of the bit being served survives and is not a lost event.
            pend_d = (pend_q & ~served) | din_eff;
            ovf_d  = ovf_q | (|(din_eff & pend_q & ~served));
            if (hs) ptr_d = dout_q - W'(1);
            if (free) begin
                valid_d = |pend_d;
                dout_d  = sel_idx(pend_d, ptr_d, mode);
            end
        end
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= W'(N - 1);
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout     = dout_q;
    assign valid    = valid_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_prio_event_enc.sv
// Directed bench for prio_event_enc (N=8) with hand-computed expectations.
module tb_prio_event_enc;

    logic       ck;
    logic       res;
    logic [7:0] din;
    logic       en;
    logic       clr;
    logic       mode;
    logic [2:0] dout;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       overflow;

    int n_tests;
    int n_fail;

    prio_event_enc #(.N(8), .W(3)) dut (
        .ck       (ck),
        .res      (res),
        .din      (din),
        .en       (en),
        .clr      (clr),
        .mode     (mode),
        .dout     (dout),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .overflow (overflow)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check_offer(input string tag, input logic [2:0] d, input logic v);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) check({tag, ".dout"}, 32'(dout), 32'(d));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        res   = 1'b0;
        din   = '0;
        en    = 1'b1;
        clr   = 1'b0;
        mode  = 1'b0;
        ready = 1'b1;

        #3;
        check("rst.dout", 32'(dout), 32'd0);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.pending", 32'(pending), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        #4 res = 1'b1;
        tick();

        // Fixed priority, two events in one pulse, consumer always ready.
        din = 8'b0010_0100;
        tick();
        din = '0;
        check_offer("fx1", 3'd5, 1'b1);
        check("fx1.pending", 32'(pending), 32'h24);
        tick();
        check_offer("fx2", 3'd2, 1'b1);
        check("fx2.pending", 32'(pending), 32'h04);
        tick();
        check_offer("fx3", 3'd0, 1'b0);
        check("fx3.pending", 32'(pending), 32'h00);

        // Offer held under backpressure even when a higher index arrives.
        ready = 1'b0;
        din   = 8'h01;
        tick();
        din = '0;
        check_offer("hold1", 3'd0, 1'b1);
        din = 8'h80;
        tick();
        din = '0;
        check_offer("hold2", 3'd0, 1'b1);
        check("hold2.pending", 32'(pending), 32'h81);
        ready = 1'b1;
        tick();
        check_offer("hold3", 3'd7, 1'b1);
        check("hold3.pending", 32'(pending), 32'h80);
        tick();
        check_offer("hold4", 3'd0, 1'b0);
        check("hold.overflow", 32'(overflow), 32'd0);

        // Clear restores ptr to 7 for the round-robin sequence.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_offer("clr0", 3'd0, 1'b0);

        mode = 1'b1;
        din  = 8'hFF;
        tick();
        din = '0;
        for (int i = 0; i < 8; i++) begin
            check_offer($sformatf("rr_ff%0d", i), 3'(7 - i), 1'b1);
            tick();
        end
        check_offer("rr_ff_end", 3'd0, 1'b0);

        for (int r = 0; r < 2; r++) begin
            din = 8'h81;
            tick();
            din = '0;
            check_offer($sformatf("rr81_%0d_a", r), 3'd7, 1'b1);
            tick();
            check_offer($sformatf("rr81_%0d_b", r), 3'd0, 1'b1);
            tick();
            check_offer($sformatf("rr81_%0d_c", r), 3'd0, 1'b0);
        end

        // Overflow on repeated request to an unserved pending bit, then clear.
        mode  = 1'b0;
        ready = 1'b0;
        din   = 8'h08;
        tick();
        check_offer("ovf1", 3'd3, 1'b1);
        check("ovf1.overflow", 32'(overflow), 32'd0);
        tick();
        check("ovf2.overflow", 32'(overflow), 32'd1);
        check("ovf2.pending", 32'(pending), 32'h08);
        tick();
        din = '0;
        check("ovf3.overflow", 32'(overflow), 32'd1);
        check("ovf3.pending", 32'(pending), 32'h08);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovfclr.pending", 32'(pending), 32'h00);
        check("ovfclr.overflow", 32'(overflow), 32'd0);
        check_offer("ovfclr", 3'd0, 1'b0);
        check("ovfclr.dout", 32'(dout), 32'd0);

        // Re-request of the bit being served in the same cycle.
        din = 8'h10;
        tick();
        din = '0;
        check_offer("same1", 3'd4, 1'b1);
        ready = 1'b1;
        din   = 8'h10;
        tick();
        din   = '0;
        ready = 1'b0;
        check_offer("same2", 3'd4, 1'b1);
        check("same2.pending", 32'(pending), 32'h10);
        check("same2.overflow", 32'(overflow), 32'd0);
        ready = 1'b1;
        tick();
        check_offer("same3", 3'd0, 1'b0);
        check("same3.pending", 32'(pending), 32'h00);

        // Clear wins over simultaneous requests; en=0 masks requests.
        clr = 1'b1;
        din = 8'hFF;
        tick();
        clr = 1'b0;
        check("clrwin.pending", 32'(pending), 32'h00);
        check_offer("clrwin", 3'd0, 1'b0);
        en = 1'b0;
        tick();
        check("en0.pending", 32'(pending), 32'h00);
        check_offer("en0", 3'd0, 1'b0);

        // Asynchronous reset in the middle of an offer.
        en    = 1'b1;
        ready = 1'b0;
        din   = 8'h04;
        tick();
        din = '0;
        check_offer("ares0", 3'd2, 1'b1);
        #3 res = 1'b0;
        #1;
        check("ares.valid", 32'(valid), 32'd0);
        check("ares.dout", 32'(dout), 32'd0);
        check("ares.pending", 32'(pending), 32'h00);
        check("ares.overflow", 32'(overflow), 32'd0);
        en  = 1'b0;
        din = 8'hFF;
        #1 res = 1'b1;
        tick();
        check("ares_en0.pending", 32'(pending), 32'h00);
        check_offer("ares_en0", 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
